// File: rtl/horizon_obstacle_ctrl_if.sv
// Shared types and the game-logic <-> obstacle-manager bus for the runner horizon.
// Kept with the interface so the types it uses are defined before it.
package horizon_pkg;
    localparam int MAX_OBSTACLES = 3;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        CACTUS_SMALL = 3'd1,
        CACTUS_LARGE = 3'd2,
        PTERO_UP     = 3'd3,
        PTERO_DOWN   = 3'd4
    } frame_t;

    typedef logic signed [10:0] xpos_t;
    typedef logic [9:0]         dim_t;
endpackage

interface horizon_obstacle_ctrl_if;
    import horizon_pkg::*;

    logic                           update;
    logic [5:0]                     timer;
    logic                           start;
    logic                           crash;
    logic [10:0]                    rng_data;
    logic [4:0]                     speed;
    xpos_t  [MAX_OBSTACLES-1:0]     obstacle_x_pos;
    dim_t   [MAX_OBSTACLES-1:0]     obstacle_y_pos;
    dim_t   [MAX_OBSTACLES-1:0]     obstacle_width;
    dim_t   [MAX_OBSTACLES-1:0]     obstacle_height;
    frame_t [MAX_OBSTACLES-1:0]     obstacle_frame;

    modport master (
        output update, timer, start, crash, rng_data, speed,
        input  obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height, obstacle_frame
    );
    modport slave (
        input  update, timer, start, crash, rng_data, speed,
        output obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height, obstacle_frame
    );
endinterface

// File: rtl/horizon_obstacle_ctrl.sv
// Obstacle manager: spawns, scrolls and retires horizon obstacles on each game tick.
// A slot with frame NONE is free; all slot fields are registered and move only on update.
module horizon_obstacle_ctrl
    import horizon_pkg::*;
#(
    parameter int SCREEN_WIDTH    = 640,
    parameter int GROUND_Y        = 400,
    parameter int MIN_GAP         = 120,
    parameter int PTERO_MIN_SPEED = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    horizon_obstacle_ctrl_if.slave  bus
);
    localparam int N = MAX_OBSTACLES;

    typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} state_t;

    state_t state, state_n;
    logic   clear, advance;

    xpos_t  [N-1:0] x_q, x_n;
    dim_t   [N-1:0] y_q, y_n, w_q, w_n, h_q, h_n;
    frame_t [N-1:0] f_q, f_n;
    logic signed [10:0] gap_q, gap_n;

    frame_t ptero_frame, sp_frame;
    dim_t   sp_w, sp_h, sp_y;
    logic   sp_ptero;

    logic signed [11:0] moved, fit, gap_dec;
    logic               free_found;
    int                 free_idx;
    logic               rng_unused;

    assign rng_unused = bus.rng_data[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUNNING;
            RUNNING: if (bus.crash) state_n = CRASHED;
            CRASHED: if (bus.start) state_n = RUNNING;
            default: state_n = IDLE;
        endcase
    end

    // Any (re)start wipes the scene; crash beats update in the same cycle.
    always_comb begin
        clear   = (state != RUNNING) && bus.start;
        advance = (state == RUNNING) && bus.update && !bus.crash;
    end

    always_comb begin
        ptero_frame = ((bus.timer % 6'd20) < 6'd10) ? PTERO_UP : PTERO_DOWN;
        sp_ptero    = 1'b0;
        sp_frame    = CACTUS_SMALL;
        sp_w        = 10'd17;
        sp_h        = 10'd35;
        case (bus.rng_data[10:9])
            2'b10: begin
                sp_frame = CACTUS_LARGE;
                sp_w     = 10'd25;
                sp_h     = 10'd50;
            end
            2'b11: if (bus.speed >= 5'(PTERO_MIN_SPEED)) begin
                sp_ptero = 1'b1;
                sp_frame = ptero_frame;
                sp_w     = 10'd46;
                sp_h     = 10'd40;
            end
            default: ;
        endcase
        if (sp_ptero) begin
            case (bus.rng_data[1:0])
                2'b00:   sp_y = 10'(GROUND_Y - 40);
                2'b01:   sp_y = 10'(GROUND_Y - 65);
                default: sp_y = 10'(GROUND_Y - 90);
            endcase
        end else begin
            sp_y = 10'(GROUND_Y) - sp_h;
        end
    end

    always_comb begin
        x_n = x_q; y_n = y_q; w_n = w_q; h_n = h_q; f_n = f_q; gap_n = gap_q;
        moved = '0; fit = '0; gap_dec = '0; free_found = 1'b0; free_idx = 0;
        if (clear) begin
            for (int i = 0; i < N; i++) begin
                x_n[i] = '0; y_n[i] = '0; w_n[i] = '0; h_n[i] = '0; f_n[i] = NONE;
            end
            gap_n = 11'(MIN_GAP);
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (f_q[i] != NONE) begin
                    moved = {x_q[i][10], x_q[i]} - {7'd0, bus.speed};
                    fit   = moved + $signed({2'b00, w_q[i]});
                    if (fit <= 12'sd0) begin
                        x_n[i] = '0; y_n[i] = '0; w_n[i] = '0; h_n[i] = '0; f_n[i] = NONE;
                    end else begin
                        x_n[i] = moved[10:0];
                        if (f_q[i] == PTERO_UP || f_q[i] == PTERO_DOWN) f_n[i] = ptero_frame;
                    end
                end
            end
            // Slots retired on this tick are already available for the spawn.
            for (int i = N - 1; i >= 0; i--) begin
                if (f_n[i] == NONE) begin
                    free_found = 1'b1;
                    free_idx   = i;
                end
            end
            gap_dec = {gap_q[10], gap_q} - {7'd0, bus.speed};
            if (gap_dec > 12'sd0) begin
                gap_n = gap_dec[10:0];
            end else if (!free_found) begin
                gap_n = '0;
            end else begin
                x_n[free_idx] = 11'(SCREEN_WIDTH);
                y_n[free_idx] = sp_y;
                w_n[free_idx] = sp_w;
                h_n[free_idx] = sp_h;
                f_n[free_idx] = sp_frame;
                gap_n = 11'(MIN_GAP) + {3'd0, bus.rng_data[7:0]} + {1'b0, sp_w};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            w_q   <= '0;
            h_q   <= '0;
            f_q   <= {N{NONE}};
            gap_q <= 11'(MIN_GAP);
        end else begin
            x_q   <= x_n;
            y_q   <= y_n;
            w_q   <= w_n;
            h_q   <= h_n;
            f_q   <= f_n;
            gap_q <= gap_n;
        end
    end

    assign bus.obstacle_x_pos  = x_q;
    assign bus.obstacle_y_pos  = y_q;
    assign bus.obstacle_width  = w_q;
    assign bus.obstacle_height = h_q;
    assign bus.obstacle_frame  = f_q;
endmodule

// File: tb/tb_horizon_obstacle_ctrl.sv
// Bench for horizon_obstacle_ctrl: directed scenarios plus a long random run,
// every cycle compared against a slot-list reference model of the game rules.
module tb_horizon_obstacle_ctrl;
    import horizon_pkg::*;
    localparam int N  = MAX_OBSTACLES;
    localparam int LR = 10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    horizon_obstacle_ctrl_if bus();
    horizon_obstacle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int vectors = 0, miscompares = 0;
    int mx[N], my[N], mw[N], mh[N], mf[N];
    int mgap, mmode;
    int prev_f[N];
    int travel, last_w, have_prev, tmr;
    int s_upd[LR], s_start[LR], s_crash[LR], s_rng[LR], s_spd[LR];
    int sig1, sig2;

    task automatic check(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dx(int i); return int'($signed(bus.obstacle_x_pos[i])); endfunction
    function automatic int dw(int i); return int'(bus.obstacle_width[i]); endfunction
    function automatic int dfr(int i); return int'(bus.obstacle_frame[i]); endfunction

    function automatic void mclear();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0; mf[i] = int'(NONE);
        end
        mgap = 120;
    endfunction

    // Reference: move live obstacles, drop ones fully off screen, spawn when the gap is used up.
    task automatic model_step();
        int spd, rng, pf, nx, slot, t;
        spd = int'(bus.speed);
        rng = int'(bus.rng_data);
        pf  = (int'(bus.timer) % 20 < 10) ? int'(PTERO_UP) : int'(PTERO_DOWN);
        if (mmode != 1) begin
            if (bus.start) begin
                mclear(); mmode = 1; have_prev = 0; travel = 0;
            end
        end else if (bus.crash) begin
            mmode = 2;
        end else if (bus.update) begin
            travel += spd;
            for (int i = 0; i < N; i++) begin
                if (mf[i] != int'(NONE)) begin
                    nx = mx[i] - spd;
                    if (nx + mw[i] <= 0) begin
                        mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0; mf[i] = int'(NONE);
                    end else begin
                        mx[i] = nx;
                        if (mf[i] == int'(PTERO_UP) || mf[i] == int'(PTERO_DOWN)) mf[i] = pf;
                    end
                end
            end
            mgap -= spd;
            if (mgap <= 0) begin
                slot = -1;
                for (int i = 0; i < N; i++) if (mf[i] == int'(NONE) && slot < 0) slot = i;
                if (slot < 0) begin
                    mgap = 0;
                end else begin
                    t = rng / 512;
                    if (t == 3 && spd >= 8) begin
                        mw[slot] = 46; mh[slot] = 40; mf[slot] = pf;
                        my[slot] = 360 - ((rng % 4 == 0) ? 0 : (rng % 4 == 1) ? 25 : 50);
                    end else if (t == 2) begin
                        mw[slot] = 25; mh[slot] = 50; mf[slot] = int'(CACTUS_LARGE); my[slot] = 350;
                    end else begin
                        mw[slot] = 17; mh[slot] = 35; mf[slot] = int'(CACTUS_SMALL); my[slot] = 365;
                    end
                    mx[slot] = 640;
                    mgap = 120 + (rng % 256) + mw[slot];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("x[%0d]", i), dx(i), mx[i]);
            check($sformatf("y[%0d]", i), int'(bus.obstacle_y_pos[i]), my[i]);
            check($sformatf("w[%0d]", i), dw(i), mw[i]);
            check($sformatf("h[%0d]", i), int'(bus.obstacle_height[i]), mh[i]);
            check($sformatf("frame[%0d]", i), dfr(i), mf[i]);
            if (prev_f[i] == 0 && dfr(i) != 0) begin
                if (have_prev != 0) check("spawn_gap_ok", int'(travel - last_w >= 120), 1);
                have_prev = 1; last_w = dw(i); travel = 0;
            end
            prev_f[i] = dfr(i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic upd(int idle);
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
        tmr = (tmr + 1) % 60;
        bus.timer = 6'(tmr);
        repeat (idle) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        mclear(); mmode = 0; have_prev = 0; travel = 0;
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic long_run(output int sig);
        sig = 0;
        for (int c = 0; c < LR; c++) begin
            bus.update   = 1'(s_upd[c]);
            bus.start    = 1'(s_start[c]);
            bus.crash    = 1'(s_crash[c]);
            bus.rng_data = 11'(s_rng[c]);
            bus.speed    = 5'(s_spd[c]);
            bus.timer    = 6'(c % 60);
            step();
            for (int i = 0; i < N; i++) sig = sig * 33 + dx(i) * 7 + dfr(i);
        end
        bus.update = 1'b0; bus.start = 1'b0; bus.crash = 1'b0;
    endtask

    initial begin
        int found, x1, spd;
        bus.update = 1'b0; bus.start = 1'b0; bus.crash = 1'b0;
        bus.timer = '0; bus.rng_data = '0; bus.speed = 5'd6;
        tmr = 0; travel = 0; have_prev = 0; last_w = 0;
        for (int i = 0; i < N; i++) prev_f[i] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Idle: updates are ignored before start.
        for (int c = 0; c < 100; c++) begin
            bus.update = (c % 3 == 0);
            step();
        end
        bus.update = 1'b0;

        // First spawn at 20th update with speed 6.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int k = 0; k < 19; k++) upd(6);
        check("no_spawn_before_20", dfr(0), int'(NONE));
        upd(6);
        check("first_spawn_x", dx(0), 640);
        upd(6);
        check("x_after_speed6", dx(0), 634);

        // Speed change takes effect on the next update; then force a ptero.
        bus.speed = 5'd9;
        upd(6);
        check("x_after_speed9", dx(0), 625);
        bus.rng_data = 11'b110_0000_0001;
        found = -1;
        for (int k = 0; k < 40 && found < 0; k++) begin
            upd(1);
            for (int i = 0; i < N; i++) if (dw(i) == 46 && found < 0) found = i;
        end
        check("ptero_spawned", int'(found >= 0), 1);
        if (found >= 0) begin
            check("ptero_h", int'(bus.obstacle_height[found]), 40);
            check("ptero_y", int'(bus.obstacle_y_pos[found]), 335);
        end

        // Restart, walk slot 0 to x=5 then retire it at speed 9.
        bus.crash = 1'b1; step(); bus.crash = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.speed = 5'd5; bus.rng_data = 11'h0FF;
        for (int k = 0; k < 200 && dx(0) != 5; k++) upd(1);
        check("slot0_at_5", dx(0), 5);
        bus.speed = 5'd9;
        upd(1);
        check("x_neg4_active", dx(0), -4);
        check("w_neg4_active", dw(0), 17);
        upd(1);
        check("x_neg13_active", dx(0), -13);
        upd(1);
        check("retired_frame", dfr(0), int'(NONE));
        check("retired_w", dw(0), 0);

        // Crash freezes the scene; start clears it and spawning resumes.
        x1 = dx(1);
        bus.crash = 1'b1;
        for (int k = 0; k < 5; k++) upd(1);
        bus.crash = 1'b0;
        upd(1);
        check("frozen_x1", dx(1), x1);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("cleared[%0d]", i), dfr(i), int'(NONE));
        for (int k = 0; k < 200 && dfr(0) == int'(NONE); k++) upd(1);
        check("spawn_after_restart", dx(0), 640);

        // Long random run, replayed after reset: must be identical.
        spd = 6;
        for (int c = 0; c < LR; c++) begin
            if ($urandom_range(199) == 0) spd = $urandom_range(31, 1);
            s_upd[c]   = int'($urandom_range(2) == 0);
            s_start[c] = int'($urandom_range(49) == 0);
            s_crash[c] = int'($urandom_range(1499) == 0);
            s_rng[c]   = int'($urandom_range(2047));
            s_spd[c]   = spd;
        end
        do_reset();
        long_run(sig1);
        do_reset();
        long_run(sig2);
        check("replay_identical", sig2, sig1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
